// File: rtl/music_pkg.sv
// ============================================================================
// Module : music_pkg
// Brief  : Note codes, sizing constants and the half-period helper for note_player.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package music_pkg;

  localparam int unsigned MUSIC_DEPTH  = 16;
  localparam int unsigned MUSIC_NOTE_W = 4;
  localparam int unsigned HALF_W       = 17;

  localparam logic [MUSIC_NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [MUSIC_NOTE_W-1:0] NOTE_C4   = 4'd1;
  localparam logic [MUSIC_NOTE_W-1:0] NOTE_CS4  = 4'd2;
  localparam logic [MUSIC_NOTE_W-1:0] NOTE_D4   = 4'd3;
  localparam logic [MUSIC_NOTE_W-1:0] NOTE_DS4  = 4'd4;
  localparam logic [MUSIC_NOTE_W-1:0] NOTE_E4   = 4'd5;
  localparam logic [MUSIC_NOTE_W-1:0] NOTE_F4   = 4'd6;
  localparam logic [MUSIC_NOTE_W-1:0] NOTE_FS4  = 4'd7;
  localparam logic [MUSIC_NOTE_W-1:0] NOTE_G4   = 4'd8;
  localparam logic [MUSIC_NOTE_W-1:0] NOTE_GS4  = 4'd9;
  localparam logic [MUSIC_NOTE_W-1:0] NOTE_A4   = 4'd10;
  localparam logic [MUSIC_NOTE_W-1:0] NOTE_AS4  = 4'd11;
  localparam logic [MUSIC_NOTE_W-1:0] NOTE_B4   = 4'd12;

  // Pitches are held in millihertz; half = floor(clk_hz / (2 * f)) = clk_hz*500 / f_mHz.
  function automatic logic [HALF_W-1:0] half_period(input logic [MUSIC_NOTE_W-1:0] code,
                                                    input int unsigned clk_hz);
    logic [63:0] f_mhz;
    logic [63:0] num;
    case (code)
      NOTE_C4:  f_mhz = 64'd261626;
      NOTE_CS4: f_mhz = 64'd277183;
      NOTE_D4:  f_mhz = 64'd293665;
      NOTE_DS4: f_mhz = 64'd311127;
      NOTE_E4:  f_mhz = 64'd329628;
      NOTE_F4:  f_mhz = 64'd349228;
      NOTE_FS4: f_mhz = 64'd369994;
      NOTE_G4:  f_mhz = 64'd391995;
      NOTE_GS4: f_mhz = 64'd415305;
      NOTE_A4:  f_mhz = 64'd440000;
      NOTE_AS4: f_mhz = 64'd466164;
      NOTE_B4:  f_mhz = 64'd493883;
      NOTE_REST: f_mhz = 64'd0;
      default:  f_mhz = 64'd0;
    endcase
    num = 64'(clk_hz) * 64'd500;
    if (f_mhz == 64'd0) begin
      return '0;
    end
    return HALF_W'(num / f_mhz);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tone_gen.sv
// ============================================================================
// Module : tone_gen
// Brief  : Reloading half-period counter that toggles a square-wave output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tone_gen
  import music_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [HALF_W-1:0] half,
  input  logic              restart,
  output logic              audio_out
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              audio_q, audio_d;

  always_comb begin
    cnt_d   = cnt_q;
    audio_d = audio_q;
    if (half == '0) begin
      cnt_d   = '0;
      audio_d = 1'b0;
    end else if (restart) begin
      // New pitch starts low so the first rising edge lands exactly half cycles later.
      cnt_d   = half - HALF_W'(1);
      audio_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d   = half - HALF_W'(1);
      audio_d = ~audio_q;
    end else begin
      cnt_d   = cnt_q - HALF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      audio_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      audio_q <= audio_d;
    end
  end

  assign audio_out = audio_q;

endmodule

`default_nettype wire

// File: rtl/note_player.sv
// ============================================================================
// Module : note_player
// Brief  : Note store with edge-triggered loading and square-wave playback.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module note_player
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned DEPTH  = MUSIC_DEPTH,
  parameter int unsigned NOTE_W = MUSIC_NOTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_note,
  input  logic              ld_play,
  input  logic [3:0]        note_counter,
  input  logic [NOTE_W-1:0] note_in,
  output logic              audio_out,
  output logic [NOTE_W-1:0] note_out,
  output logic [4:0]        note_count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned NCODES = 2 ** NOTE_W;

  logic [NOTE_W-1:0] mem_q [DEPTH];
  logic [NOTE_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [4:0]        count_q, count_d;
  logic [NOTE_W-1:0] cur_note_q, cur_note_d;
  logic              ld_note_q;

  logic              w_wr;
  logic              w_restart;
  logic [HALF_W-1:0] w_half;
  logic [HALF_W-1:0] w_half_tbl [NCODES];

  // Constant-folded lookup; no divider survives synthesis.
  for (genvar gi = 0; gi < NCODES; gi++) begin : g_half
    assign w_half_tbl[gi] = half_period(MUSIC_NOTE_W'(gi), CLK_HZ);
  end

  assign w_wr = ld_note & ~ld_note_q & ~ld_play;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (w_wr) begin
      mem_d[wr_ptr_q] = note_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      if (count_q != 5'(DEPTH)) begin
        count_d = count_q + 5'd1;
      end
    end
  end

  always_comb begin
    cur_note_d = '0;
    if (ld_play) begin
      cur_note_d = mem_q[note_counter];
    end
  end

  // Tone generator sees the upcoming note so its reload coincides with cur_note updating.
  assign w_half    = w_half_tbl[cur_note_d];
  assign w_restart = (cur_note_d != cur_note_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cur_note_q <= '0;
      ld_note_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cur_note_q <= cur_note_d;
      ld_note_q  <= ld_note;
    end
  end

  tone_gen u_tone_gen (
    .clk       (clk),
    .reset     (reset),
    .half      (w_half),
    .restart   (w_restart),
    .audio_out (audio_out)
  );

  assign note_out   = cur_note_q;
  assign note_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_note_player.sv
// ============================================================================
// Module : tb_note_player
// Brief  : Directed, table-driven self-checking bench for note_player.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_note_player;

  // Scaled clock keeps tone periods short: halves are floor(50 MHz table / 100).
  localparam int unsigned TB_CLK_HZ = 500_000;
  localparam int H1  = 955;
  localparam int H5  = 758;
  localparam int H10 = 568;
  localparam int H12 = 506;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ld_note = 1'b0;
  logic       ld_play = 1'b0;
  logic [3:0] note_counter = '0;
  logic [3:0] note_in = '0;
  logic       audio_out;
  logic [3:0] note_out;
  logic [4:0] note_count;

  int checks = 0;
  int failures = 0;

  note_player #(.CLK_HZ(TB_CLK_HZ)) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_note      (ld_note),
    .ld_play      (ld_play),
    .note_counter (note_counter),
    .note_in      (note_in),
    .audio_out    (audio_out),
    .note_out     (note_out),
    .note_count   (note_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ln;
    logic       lp;
    logic [3:0] nc;
    logic [3:0] ni;
    logic [4:0] e_cnt;
    logic [3:0] e_out;
    logic       e_aud;
    string      name;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ln, input logic lp, input logic [3:0] nc, input logic [3:0] ni);
    @(negedge clk);
    ld_note      = ln;
    ld_play      = lp;
    note_counter = nc;
    note_in      = ni;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load(input logic [3:0] v);
    drive(1'b1, 1'b0, 4'd0, v);
    step();
    drive(1'b0, 1'b0, 4'd0, v);
    step();
  endtask

  // Counts clock edges until audio_out reaches lvl, bounded by limit.
  task automatic edges_until(input logic lvl, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (audio_out !== lvl && n < limit);
  endtask

  initial begin
    int n, n2, hi;
    int exp_h [16];
    logic [3:0] v;

    exp_h = '{0, 95556, 90193, 85131, 80353, 75843, 71586, 67568,
              63776, 60196, 56818, 53629, 50619, 0, 0, 0};

    //               ln    lp    nc     ni     cnt    out    aud
    vecs[0]  = '{1'b0, 1'b1, 4'd0, 4'd0,  5'd0, 4'd0,  1'b0, "play_empty0"};
    vecs[1]  = '{1'b0, 1'b1, 4'd5, 4'd0,  5'd0, 4'd0,  1'b0, "play_empty5"};
    vecs[2]  = '{1'b1, 1'b1, 4'd0, 4'd7,  5'd0, 4'd0,  1'b0, "both_high"};
    vecs[3]  = '{1'b1, 1'b0, 4'd0, 4'd7,  5'd0, 4'd0,  1'b0, "play_drop_hold"};
    vecs[4]  = '{1'b0, 1'b0, 4'd0, 4'd7,  5'd0, 4'd0,  1'b0, "release"};
    vecs[5]  = '{1'b1, 1'b0, 4'd0, 4'd10, 5'd1, 4'd0,  1'b0, "write10"};
    vecs[6]  = '{1'b1, 1'b0, 4'd0, 4'd3,  5'd1, 4'd0,  1'b0, "hold_a"};
    vecs[7]  = '{1'b1, 1'b0, 4'd0, 4'd3,  5'd1, 4'd0,  1'b0, "hold_b"};
    vecs[8]  = '{1'b0, 1'b0, 4'd0, 4'd3,  5'd1, 4'd0,  1'b0, "release2"};
    vecs[9]  = '{1'b0, 1'b1, 4'd1, 4'd0,  5'd1, 4'd0,  1'b0, "play_unwritten"};
    vecs[10] = '{1'b0, 1'b1, 4'd0, 4'd0,  5'd1, 4'd10, 1'b0, "play_slot0"};

    // Half-period table at the nominal 50 MHz clock.
    for (int c = 0; c < 16; c++) begin
      check($sformatf("half_tbl_%0d", c),
            32'(music_pkg::half_period(4'(c), 32'd50_000_000)), exp_h[c]);
    end

    repeat (3) step();
    check("rst_count", 32'(note_count), 0);
    check("rst_note_out", 32'(note_out), 0);
    check("rst_audio", 32'(audio_out), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].ln, vecs[i].lp, vecs[i].nc, vecs[i].ni);
      step();
      check({vecs[i].name, "_count"}, 32'(note_count), 32'(vecs[i].e_cnt));
      check({vecs[i].name, "_out"}, 32'(note_out), 32'(vecs[i].e_out));
      check({vecs[i].name, "_audio"}, 32'(audio_out), 32'(vecs[i].e_aud));
    end

    // Code 10 tone: first rise and full period from the cur_note update edge.
    edges_until(1'b1, 3 * H10, n);
    check("a4_first_rise", n, H10);
    edges_until(1'b0, 3 * H10, n);
    edges_until(1'b1, 3 * H10, n2);
    check("a4_period", n + n2, 2 * H10);
    check("a4_note_out", 32'(note_out), 10);
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    step();
    check("stop_audio", 32'(audio_out), 0);
    check("stop_note_out", 32'(note_out), 0);

    // Seventeen loads: saturation and wrap onto slot 0.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      v = (i < 15) ? 4'(i + 1) : ((i == 15) ? 4'd1 : 4'd12);
      load(v);
      if (i == 14) check("count_15", 32'(note_count), 15);
      if (i == 15) check("count_16", 32'(note_count), 16);
    end
    check("count_sat", 32'(note_count), 16);
    drive(1'b0, 1'b1, 4'd1, 4'd0);
    step();
    check("slot1", 32'(note_out), 2);
    drive(1'b0, 1'b1, 4'd0, 4'd0);
    step();
    check("slot0_wrap", 32'(note_out), 12);
    edges_until(1'b1, 3 * H12, n);
    check("b4_first_rise", n, H12);

    // Note change while the tone is high forces it low and restarts timing.
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    do_reset();
    load(4'd1);
    load(4'd5);
    drive(1'b0, 1'b1, 4'd0, 4'd0);
    step();
    check("c4_note_out", 32'(note_out), 1);
    edges_until(1'b1, 3 * H1, n);
    check("c4_first_rise", n, H1);
    repeat (100) step();
    check("c4_still_high", 32'(audio_out), 1);
    drive(1'b0, 1'b1, 4'd1, 4'd0);
    step();
    check("switch_audio_low", 32'(audio_out), 0);
    check("switch_note_out", 32'(note_out), 5);
    edges_until(1'b1, 3 * H5, n);
    check("e4_first_rise", n - 1, H5 - 1);

    // Load held across the end of playback: no write.
    drive(1'b1, 1'b1, 4'd1, 4'd9);
    step();
    drive(1'b1, 1'b0, 4'd1, 4'd9);
    repeat (4) step();
    drive(1'b0, 1'b0, 4'd1, 4'd9);
    step();
    check("overlap_count", 32'(note_count), 2);
    drive(1'b0, 1'b1, 4'd2, 4'd0);
    step();
    check("overlap_slot2", 32'(note_out), 0);

    // Reset for one cycle while the tone is high and playback stays on.
    drive(1'b0, 1'b1, 4'd0, 4'd0);
    step();
    edges_until(1'b1, 3 * H1, n);
    check("pre_reset_high", 32'(audio_out), 1);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("mid_rst_audio", 32'(audio_out), 0);
    check("mid_rst_note_out", 32'(note_out), 0);
    check("mid_rst_count", 32'(note_count), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      drive(1'b0, 1'b1, 4'(s), 4'd0);
      step();
      check($sformatf("post_rst_slot%0d", s), 32'(note_out), 0);
    end

    // Codes above 12 are rests.
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    step();
    load(4'd13);
    drive(1'b0, 1'b1, 4'd0, 4'd0);
    step();
    check("rest13_note_out", 32'(note_out), 13);
    hi = 0;
    repeat (1200) begin
      step();
      if (audio_out !== 1'b0) hi++;
    end
    check("rest13_silent", hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/note_player.md
Name: note_player

Overview:
- Datapath partner of the playback control FSM.
- Stores up to 16 user-entered note codes on each load strobe from the FSM.
- During playback, reads the note selected by the FSM's note_counter and drives a square-wave audio bit at that note's pitch.
- Sits between the control FSM, the switch inputs and the audio/speaker output.

Parameters:
- CLK_HZ, 50000000, system clock frequency; used to derive the note half-period table.
- DEPTH, 16, number of note slots; must equal 2**4 to match note_counter.
- NOTE_W, 4, width of a note code.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous reset, active-high
- ld_note  input  1  level from control FSM; high while the user holds load
- ld_play  input  1  level from control FSM; high during playback
- note_counter  input  4  slot index to play, from control FSM
- note_in  input  NOTE_W  note code from switches
- audio_out  output  1  square-wave tone to the speaker/DAC
- note_out  output  NOTE_W  note currently sounding, for hex display
- note_count  output  5  number of slots written, saturating at 16

Behaviour:
- Reset (synchronous, active-high): all mem slots=0, wr_ptr=0, note_count=0, cur_note=0, audio_out=0, note_out=0, tone counter=0, ld_note_q=0.
- Note codes: 0=rest; 1..12 = C4..B4 chromatically; 13..15 are treated as rest.
- Write path:
  - ld_note_q registers ld_note each cycle.
  - A write fires on a rising edge only, i.e. ld_note & ~ld_note_q & ~ld_play.
  - On a write: mem[wr_ptr] <= note_in; wr_ptr <= wr_ptr+1 (4-bit, wraps 15->0 and overwrites slot 0); note_count <= min(note_count+1, 16).
  - Holding ld_note high for many cycles produces exactly one write.
- Simultaneous ld_note and ld_play: ld_play wins and no write occurs. If ld_play then drops while ld_note is still high, no write occurs, because ld_note_q is already 1.
- Read path:
  - While ld_play=1: cur_note <= mem[note_counter] every cycle (1-cycle latency); note_out=cur_note.
  - While ld_play=0: cur_note <= 0 and audio_out <= 0 next cycle.
  - Unwritten slots read 0, so they play as rest.
- Tone generation:
  - half = HALF_PERIOD(cur_note) from the package table; 0 for rest.
  - If half==0: counter=0, audio_out=0.
  - Whenever cur_note changes: counter <= half-1, audio_out <= 0.
  - Otherwise, when counter==0: audio_out toggles and counter <= half-1; else counter decrements.
  - Output period is 2*half clk cycles; audio_out's first rising edge comes exactly half cycles after cur_note updates.
- Half-period values at 50 MHz (floor of CLK_HZ/(2*f)): 1:95556 2:90193 3:85131 4:80353 5:75843 6:71586 7:67568 8:63776 9:60196 10:56818 11:53629 12:50619. The counter is 17 bits.
- A write during playback cannot occur (suppressed above), so the table is stable while playing.
- Reset mid-playback returns every output to its reset value on the next edge, regardless of ld_play.

Decomposition:
- Shared package music_pkg:
  - note code localparams (NOTE_REST, NOTE_C4..NOTE_B4)
  - function half_period(code, CLK_HZ) returning 17-bit values
  - DEPTH/NOTE_W constants
- One sub-module, tone_gen:
  - inputs: clk, reset, half[16:0], restart
  - output: audio_out
  - contains the reload counter and toggle logic.
- note_player holds the mem array, write pointer/edge detect, read register and tone_gen instance.

Test Plan:
- Reset, then ld_play=1 with note_counter=0 -> audio_out stays 0, note_out=0, note_count=0.
- note_in=10; hold ld_note high 20 cycles; ld_note=0; ld_play=1, note_counter=0 -> note_count=1; note_out=10 one cycle later; audio_out first rises 56818 cycles after cur_note updates, with period 113636.
- Load 17 notes with values 1,2,...,15,1,12 -> note_count saturates at 16; slot0=12 (overwritten), slot1=2; playing slot 0 gives half-period 50619.
- Playing code 1 with note_counter switching 0->1 (slot1=5) mid-cycle -> audio_out forced 0 on change, next rise after 75843 cycles.
- ld_note and ld_play both high, then ld_play drops while ld_note stays high -> no write; note_count unchanged.
- Assert reset for 1 cycle mid-tone -> next cycle audio_out=0, note_count=0, all slots read 0.
